// File: rtl/forward_east_west_pkg.sv
// rtl/forward_east_west_pkg.sv - shared spike-router widths, field offsets, FSM and target encodings
package forward_east_west_pkg;

    localparam int DX_WIDTH_DEFAULT      = 9;
    localparam int DY_WIDTH_DEFAULT      = 9;
    localparam int PAYLOAD_WIDTH_DEFAULT = 12;

    localparam int DY_LSB = PAYLOAD_WIDTH_DEFAULT;
    localparam int DX_LSB = DY_WIDTH_DEFAULT + PAYLOAD_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TGT_EAST = 2'd0,
        TGT_WEST = 2'd1,
        TGT_NS   = 2'd2
    } target_e;

endpackage

// File: rtl/forward_east_west.sv
// rtl/forward_east_west.sv - horizontal spike routing stage: pops a packet, steps dx toward zero, writes east/west/ns
module forward_east_west
    import forward_east_west_pkg::*;
#(
    parameter int DX_WIDTH      = DX_WIDTH_DEFAULT,
    parameter int DY_WIDTH      = DY_WIDTH_DEFAULT,
    parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEFAULT,
    parameter int PACKET_WIDTH  = DX_WIDTH + DY_WIDTH + PAYLOAD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PACKET_WIDTH-1:0]       din,
    input  logic                          in_empty,
    output logic                          read_en,
    input  logic                          east_full,
    input  logic                          west_full,
    input  logic                          ns_full,
    output logic [PACKET_WIDTH-1:0]       dout_ew,
    output logic                          wen_east,
    output logic                          wen_west,
    output logic [DY_WIDTH+PAYLOAD_WIDTH-1:0] dout_ns,
    output logic                          wen_ns
);

    localparam int TAIL_WIDTH = DY_WIDTH + PAYLOAD_WIDTH;

    state_e                  state_q;
    target_e                 target_q;
    target_e                 target_d;
    logic [DX_WIDTH-1:0]     dx_in;
    logic [DX_WIDTH-1:0]     dx_d;
    logic [TAIL_WIDTH-1:0]   tail_in;
    logic                    target_full;

    assign dx_in   = din[PACKET_WIDTH-1 -: DX_WIDTH];
    assign tail_in = din[TAIL_WIDTH-1:0];

    // Stepping toward zero can never wrap, even at the most negative dx.
    always_comb begin
        dx_d     = dx_in;
        target_d = TGT_NS;
        if (dx_in[DX_WIDTH-1]) begin
            target_d = TGT_WEST;
            dx_d     = dx_in + DX_WIDTH'(1);
        end else if (dx_in != '0) begin
            target_d = TGT_EAST;
            dx_d     = dx_in - DX_WIDTH'(1);
        end
    end

    always_comb begin
        target_full = ns_full;
        case (target_q)
            TGT_EAST: target_full = east_full;
            TGT_WEST: target_full = west_full;
            default:  target_full = ns_full;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            target_q <= TGT_EAST;
            read_en  <= 1'b0;
            wen_east <= 1'b0;
            wen_west <= 1'b0;
            wen_ns   <= 1'b0;
            dout_ew  <= '0;
            dout_ns  <= '0;
        end else begin
            wen_east <= 1'b0;
            wen_west <= 1'b0;
            wen_ns   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!in_empty) begin
                        read_en <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    read_en  <= 1'b0;
                    target_q <= target_d;
                    if (target_d == TGT_NS) dout_ns <= tail_in;
                    else                    dout_ew <= {dx_d, tail_in};
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    // A stalled target holds everything; non-target full flags are never looked at.
                    if (!target_full) begin
                        wen_east <= (target_q == TGT_EAST);
                        wen_west <= (target_q == TGT_WEST);
                        wen_ns   <= (target_q == TGT_NS);
                        read_en  <= !in_empty;
                        state_q  <= in_empty ? S_IDLE : S_READ;
                    end
                end
                default: begin
                    read_en <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_east_west.sv
// tb/tb_forward_east_west.sv - table-driven and scoreboard bench for forward_east_west
module tb_forward_east_west;
    import forward_east_west_pkg::*;

    localparam int PW = 30;
    localparam int NW = 21;

    typedef struct {
        logic [PW-1:0] pkt;
        target_e       tgt;
        logic [PW-1:0] exp;
        logic          ef;
        logic          wf;
        logic          nf;
    } vec_t;

    typedef struct {
        target_e       tgt;
        logic [PW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [PW-1:0] din;
    logic          in_empty;
    logic          read_en;
    logic          east_full;
    logic          west_full;
    logic          ns_full;
    logic [PW-1:0] dout_ew;
    logic          wen_east;
    logic          wen_west;
    logic [NW-1:0] dout_ns;
    logic          wen_ns;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int coinc  = 0;

    logic [PW-1:0] in_q[$];
    exp_t          exp_q[$];
    int            read_log[$];
    int            wen_log[$];
    vec_t          vecs[6];

    forward_east_west dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_empty  (in_empty),
        .read_en   (read_en),
        .east_full (east_full),
        .west_full (west_full),
        .ns_full   (ns_full),
        .dout_ew   (dout_ew),
        .wen_east  (wen_east),
        .wen_west  (wen_west),
        .dout_ns   (dout_ns),
        .wen_ns    (wen_ns)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [PW-1:0] mk(logic [8:0] dx, logic [8:0] dy, logic [11:0] pl);
        return (PW'(dx) << DX_LSB) | (PW'(dy) << DY_LSB) | PW'(pl);
    endfunction

    always @(negedge clk) begin
        edge_n++;
        if (rst && read_en && in_q.size() > 0) in_q.delete(0);
    end

    always @(posedge clk) begin
        in_empty = (in_q.size() == 0);
        din      = (in_q.size() > 0) ? in_q[0] : '0;
    end

    always @(posedge clk) begin
        exp_t    e;
        target_e got;
        if (read_en) read_log.push_back(edge_n);
        if (wen_east || wen_west || wen_ns) begin
            check("wen_onehot", 32'($countones({wen_east, wen_west, wen_ns})), 32'd1);
            wen_log.push_back(edge_n);
            if (read_en) coinc++;
            got = wen_east ? TGT_EAST : (wen_west ? TGT_WEST : TGT_NS);
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'(got), 32'hFF);
            end else begin
                e = exp_q.pop_front();
                check("wen_target", 32'(got), 32'(e.tgt));
                check("wen_data", (e.tgt == TGT_NS) ? 32'(dout_ns) : 32'(dout_ew), 32'(e.data));
            end
        end
    end

    task automatic push(logic [PW-1:0] pkt, target_e tgt, logic [PW-1:0] exp, bit expect_write);
        exp_t e;
        @(negedge clk); #1;
        in_q.push_back(pkt);
        if (expect_write) begin
            e.tgt = tgt;
            e.data = exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_read_en"}, 32'(read_en), 32'd0);
        check({tag, "_wens"}, 32'({wen_east, wen_west, wen_ns}), 32'd0);
        check({tag, "_dout_ew"}, 32'(dout_ew), 32'd0);
        check({tag, "_dout_ns"}, 32'(dout_ns), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int wb;
        int rb;
        int cb;
        int rel;

        vecs[0] = '{mk(9'd3,   9'd5,   12'h0A1), TGT_EAST, mk(9'd2,   9'd5,   12'h0A1), 1'b0, 1'b1, 1'b1};
        vecs[1] = '{mk(9'h1FF, 9'h1FE, 12'hFFF), TGT_WEST, mk(9'd0,   9'h1FE, 12'hFFF), 1'b1, 1'b0, 1'b1};
        vecs[2] = '{mk(9'h100, 9'd3,   12'h055), TGT_WEST, mk(9'h101, 9'd3,   12'h055), 1'b0, 1'b0, 1'b0};
        vecs[3] = '{mk(9'd0,   9'd7,   12'h123), TGT_NS,   30'h07123,                  1'b1, 1'b1, 1'b0};
        vecs[4] = '{mk(9'h0FF, 9'd1,   12'h001), TGT_EAST, mk(9'h0FE, 9'd1,   12'h001), 1'b0, 1'b0, 1'b1};
        vecs[5] = '{mk(9'd1,   9'h1FF, 12'hABC), TGT_EAST, mk(9'd0,   9'h1FF, 12'hABC), 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        in_empty = 1'b1;
        din = '0;
        east_full = 1'b0;
        west_full = 1'b0;
        ns_full = 1'b0;
        repeat (3) @(posedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            east_full = vecs[i].ef;
            west_full = vecs[i].wf;
            ns_full   = vecs[i].nf;
            push(vecs[i].pkt, vecs[i].tgt, vecs[i].exp, 1'b1);
            drain(20);
            if (wen_log.size() > 0 && read_log.size() > 0)
                check("latency_read_to_wen", 32'(wen_log[$] - read_log[$]), 32'd2);
            else
                check("latency_logged", 32'd0, 32'd1);
        end

        @(posedge clk);
        east_full = 1'b1;
        west_full = 1'b1;
        ns_full = 1'b0;
        wb = wen_log.size();
        push(mk(9'd4, 9'd3, 12'h777), TGT_EAST, mk(9'd3, 9'd3, 12'h777), 1'b1);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("bp_no_wen", 32'(wen_log.size()), 32'(wb));
            check("bp_dout_stable", 32'(dout_ew), 32'(mk(9'd3, 9'd3, 12'h777)));
        end
        @(posedge clk);
        east_full = 1'b0;
        rel = edge_n + 1;
        drain(10);
        check("bp_release_edge", 32'(wen_log[$]), 32'(rel));

        @(posedge clk);
        west_full = 1'b0;
        wb = wen_log.size();
        rb = read_log.size();
        cb = coinc;
        @(negedge clk); #1;
        begin
            logic [PW-1:0] p[4];
            exp_t          x[4];
            p[0] = mk(9'd2,   9'd1, 12'h111); x[0] = '{TGT_EAST, mk(9'd1,   9'd1, 12'h111)};
            p[1] = mk(9'h1FE, 9'd2, 12'h222); x[1] = '{TGT_WEST, mk(9'h1FF, 9'd2, 12'h222)};
            p[2] = mk(9'd0,   9'd3, 12'h333); x[2] = '{TGT_NS,   30'h03333};
            p[3] = mk(9'd5,   9'd4, 12'h444); x[3] = '{TGT_EAST, mk(9'd4,   9'd4, 12'h444)};
            for (int i = 0; i < 4; i++) begin
                in_q.push_back(p[i]);
                exp_q.push_back(x[i]);
            end
        end
        drain(40);
        check("b2b_wen_count", 32'(wen_log.size() - wb), 32'd4);
        check("b2b_read_count", 32'(read_log.size() - rb), 32'd4);
        check("b2b_coincident", 32'(coinc - cb), 32'd3);
        if (wen_log.size() - wb == 4 && read_log.size() - rb == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_wen_spacing", 32'(wen_log[wb+i] - wen_log[wb+i-1]), 32'd2);
                check("b2b_read_spacing", 32'(read_log[rb+i] - read_log[rb+i-1]), 32'd2);
            end
        end

        @(posedge clk);
        east_full = 1'b1;
        push(mk(9'd2, 9'd9, 12'h0BB), TGT_EAST, '0, 1'b0);
        repeat (5) @(posedge clk);
        check("pre_reset_dout_loaded", 32'(dout_ew), 32'(mk(9'd1, 9'd9, 12'h0BB)));
        rst = 1'b0;
        in_q.delete();
        @(posedge clk);
        check_idle_outputs("midreset");
        rst = 1'b1;
        east_full = 1'b0;
        wb = wen_log.size();
        repeat (6) @(posedge clk);
        check("post_reset_no_wen", 32'(wen_log.size()), 32'(wb));
        push(mk(9'd0, 9'h1FF, 12'h800), TGT_NS, 30'h1FF800, 1'b1);
        drain(20);
        check("post_reset_wen_count", 32'(wen_log.size() - wb), 32'd1);

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
